// File: rtl/contador_pkg.sv
// Shared types and constants for the run/pause/clear sequencer of the 4-digit BCD counter.
package contador_pkg;

   localparam int DIGIT_W  = 4;
   localparam int N_DIGITS = 4;
   localparam int CNT_W    = DIGIT_W * N_DIGITS;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic start;
      logic pause;
      logic clear;
   } btn_pulse_t;

   // A limit holding any non-decimal nibble can never match a real count.
   function automatic logic is_bcd(input logic [CNT_W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < N_DIGITS; i++)
         if (v[i*DIGIT_W +: DIGIT_W] > BCD_MAX) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/contador_control_btn.sv
// One push-button conditioner: two-flop synchroniser, debounce counter and
// registered rising-edge pulse of the debounced level.
module btn_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          level;
   logic          level_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync    <= '0;
         cnt     <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
         pulse   <= 1'b0;
      end else begin
         sync <= {sync[0], btn};
         // Any sample agreeing with the current level restarts the run count.
         if (sync[1] != level) begin
            if (cnt == CNT_LAST) begin
               level <= sync[1];
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
         level_d <= level;
         pulse   <= level & ~level_d;
      end
   end

endmodule

// File: rtl/contador_control.sv
// Sequencer between the board buttons/clock divider and the BCD counter chain:
// gates the slow tick into digit 0, issues the global clear, stops at the limit.
module contador_control
   import contador_pkg::*;
#(
   parameter int DEB_CYCLES = 4,
   parameter bit LIMIT_EN   = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             start_btn,
   input  logic             pause_btn,
   input  logic             clear_btn,
   input  logic [CNT_W-1:0] limit,
   input  logic [CNT_W-1:0] qdata,
   output logic             ena0_out,
   output logic             rstcnt_out,
   output logic [1:0]       state_out,
   output logic             done
);

   btn_pulse_t pls;
   state_t     state, state_nxt;
   logic       hit;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start (
      .clk(clk), .rst(rst), .btn(start_btn), .pulse(pls.start));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_pause (
      .clk(clk), .rst(rst), .btn(pause_btn), .pulse(pls.pause));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clear (
      .clk(clk), .rst(rst), .btn(clear_btn), .pulse(pls.clear));

   assign hit = LIMIT_EN && is_bcd(limit) && (qdata == limit);

   always_comb begin
      state_nxt = state;
      if (pls.clear) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (pls.start) state_nxt = RUN;
            RUN:     if (pls.pause) state_nxt = PAUSE;
                     else if (hit)  state_nxt = DONE;
            PAUSE:   if (pls.start) state_nxt = RUN;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         rstcnt_out <= 1'b1;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         rstcnt_out <= pls.clear;
         done       <= (state_nxt == DONE);
      end
   end

   // Gating on hit keeps the counter parked exactly on the limit value.
   assign ena0_out  = tick && (state == RUN) && !hit;
   assign state_out = state;

endmodule

// File: tb/tb_contador_control.sv
// Directed bench for contador_control: reset, debounce latency, limit stop,
// pause/resume, clear priority and free-run wrap.
module tb_contador_control;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick;
   logic        start_btn, pause_btn, clear_btn;
   logic [15:0] limit;
   logic [15:0] qdata;
   logic        ena0_out, rstcnt_out, done;
   logic [1:0]  state_out;
   logic        free_ena0, free_rstcnt, free_done;
   logic [1:0]  free_state;

   logic        model_en = 1'b1;
   logic [15:0] q_model = 16'h0000;
   logic [15:0] q_man = 16'h0000;
   int          n_ena = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   assign qdata = model_en ? q_model : q_man;

   contador_control #(.DEB_CYCLES(4), .LIMIT_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst), .tick(tick), .start_btn(start_btn),
      .pause_btn(pause_btn), .clear_btn(clear_btn), .limit(limit),
      .qdata(qdata), .ena0_out(ena0_out), .rstcnt_out(rstcnt_out),
      .state_out(state_out), .done(done));

   contador_control #(.DEB_CYCLES(4), .LIMIT_EN(1'b0)) u_free (
      .clk(clk), .rst(rst), .tick(tick), .start_btn(start_btn),
      .pause_btn(pause_btn), .clear_btn(clear_btn), .limit(limit),
      .qdata(qdata), .ena0_out(free_ena0), .rstcnt_out(free_rstcnt),
      .state_out(free_state), .done(free_done));

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < 4; i++) begin
         if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
         else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            break;
         end
      end
      return r;
   endfunction

   // Behavioural stand-in for the BCD counter chain driven by the DUT.
   always @(posedge clk) begin
      if (rstcnt_out) q_model <= 16'h0000;
      else if (ena0_out) q_model <= bcd_inc(q_model);
      if (ena0_out) n_ena <= n_ena + 1;
   end

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit tk);
      @(negedge clk);
      tick = tk;
      #1;
   endtask

   // Hold the given buttons 10 cycles; the state must move exactly at press+8 edges.
   task automatic press(input logic s, input logic p, input logic c,
                        input logic [1:0] exp, input string tag);
      logic [1:0] prev;
      prev = state_out;
      start_btn = s; pause_btn = p; clear_btn = c;
      repeat (7) step(1'b0);
      chk(state_out, prev, {tag, "_early"});
      step(1'b0);
      chk(state_out, exp, {tag, "_state"});
      if (c) begin
         chk(rstcnt_out, 1'b1, {tag, "_rstcnt_hi"});
         chk(done, 1'b0, {tag, "_done"});
      end
      step(1'b0);
      if (c) chk(rstcnt_out, 1'b0, {tag, "_rstcnt_lo"});
      step(1'b0);
      chk(state_out, exp, {tag, "_hold"});
      start_btn = 1'b0; pause_btn = 1'b0; clear_btn = 1'b0;
      repeat (10) step(1'b0);
      chk(state_out, exp, {tag, "_release"});
   endtask

   initial begin
      int base;
      rst = 1'b0; tick = 1'b0; limit = 16'h0012;
      start_btn = 1'b0; pause_btn = 1'b0; clear_btn = 1'b0;

      // reset held three cycles with tick toggling
      for (int i = 0; i < 3; i++) begin
         step(i[0] == 1'b0);
         chk(rstcnt_out, 1'b1, "rst_rstcnt");
         chk(state_out, 2'd0, "rst_state");
         chk(ena0_out, 1'b0, "rst_ena0");
         chk(done, 1'b0, "rst_done");
      end
      rst = 1'b1;
      step(1'b1);
      chk(rstcnt_out, 1'b0, "rst_release_rstcnt");
      chk(ena0_out, 1'b0, "idle_tick_blocked");

      // short glitch must be filtered
      start_btn = 1'b1;
      step(1'b0); step(1'b0);
      start_btn = 1'b0;
      repeat (12) step(1'b0);
      chk(state_out, 2'd0, "glitch_ignored");

      press(1'b1, 1'b0, 1'b0, 2'd1, "start");
      base = n_ena;
      step(1'b1);
      chk(ena0_out, 1'b1, "run_tick_pass");
      step(1'b0);
      chk(ena0_out, 1'b0, "run_no_tick");

      // count to 0012 with a tick every other cycle
      for (int i = 0; i < 200 && state_out != 2'd3; i++) step(i[0] == 1'b0);
      chk(state_out, 2'd3, "limit_state");
      chk(done, 1'b1, "limit_done");
      chk(q_model, 16'h0012, "limit_count");
      chk(n_ena - base, 12, "limit_pulses");
      step(1'b1);
      chk(ena0_out, 1'b0, "done_tick_blocked");
      step(1'b1);
      chk(q_model, 16'h0012, "done_count_held");

      press(1'b0, 1'b0, 1'b1, 2'd0, "clear_from_done");
      chk(q_model, 16'h0000, "clear_count");

      press(1'b1, 1'b0, 1'b0, 2'd1, "start2");
      press(1'b0, 1'b1, 1'b0, 2'd2, "pause");
      step(1'b1);
      chk(ena0_out, 1'b0, "pause_tick_blocked");
      press(1'b1, 1'b0, 1'b0, 2'd1, "resume");
      press(1'b1, 1'b1, 1'b0, 2'd2, "pause_over_start");
      press(1'b1, 1'b0, 1'b1, 2'd0, "clear_over_start");

      // manual qdata: non-BCD limit and free-run wrap
      model_en = 1'b0;
      press(1'b1, 1'b0, 1'b0, 2'd1, "start3");
      limit = 16'h00A0; q_man = 16'h00A0;
      step(1'b1);
      chk(ena0_out, 1'b1, "nonbcd_limit_no_hit");
      step(1'b0);
      chk(state_out, 2'd1, "nonbcd_limit_state");
      limit = 16'h9999; q_man = 16'h9998;
      step(1'b1);
      chk(free_ena0, 1'b1, "free_9998");
      chk(ena0_out, 1'b1, "lim_9998");
      q_man = 16'h9999;
      step(1'b1);
      chk(free_ena0, 1'b1, "free_9999");
      chk(ena0_out, 1'b0, "lim_9999_hit");
      q_man = 16'h0000;
      step(1'b1);
      chk(free_ena0, 1'b1, "free_0000");
      chk(free_state, 2'd1, "free_state");
      chk(free_done, 1'b0, "free_done");
      chk(free_rstcnt, 1'b0, "free_rstcnt");
      chk(state_out, 2'd3, "lim_done_state");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
